// File: rtl/hazard_scoreboard_if.sv
// ============================================================================
// Module   : hazard_scoreboard_if
// Purpose  : Pipeline-stage bundle between the datapath and hazard_scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_scoreboard_if #(
   parameter int AW = 4,
   parameter int CW = 16
);
   localparam int NREG = 2**AW;

   logic [AW-1:0]   RA1D, RA2D, WA3D;
   logic            RegWriteD, MCycleD;
   logic [AW-1:0]   RA1E, RA2E, WA3E;
   logic            RegWriteE, MemtoRegE, PCSrcE, MCycleStartE;
   logic [AW-1:0]   WA3M, RA2M, WA3W;
   logic            RegWriteM, MemWriteM, MemtoRegM, RegWriteW, MemtoRegW;
   logic            MCycleDone;
   logic [AW-1:0]   MCycleWA;
   logic            StatClr;

   logic            StallF, StallD, FlushD, FlushE;
   logic [1:0]      ForwardAE, ForwardBE;
   logic            ForwardM;
   logic            MBusy;
   logic [NREG-1:0] SbPending;
   logic [CW-1:0]   StallCnt;

   modport master (
      output RA1D, RA2D, WA3D, RegWriteD, MCycleD,
             RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, PCSrcE, MCycleStartE,
             WA3M, RA2M, WA3W, RegWriteM, MemWriteM, MemtoRegM, RegWriteW, MemtoRegW,
             MCycleDone, MCycleWA, StatClr,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardM,
             MBusy, SbPending, StallCnt
   );

   modport slave (
      input  RA1D, RA2D, WA3D, RegWriteD, MCycleD,
             RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, PCSrcE, MCycleStartE,
             WA3M, RA2M, WA3W, RegWriteM, MemWriteM, MemtoRegM, RegWriteW, MemtoRegW,
             MCycleDone, MCycleWA, StatClr,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardM,
             MBusy, SbPending, StallCnt
   );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Pipeline hazard unit with forwarding, stalls and a multi-cycle
//            destination scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
   parameter int AW     = 4,
   parameter int PC_IDX = 15,
   parameter int FWD_EN = 1,
   parameter int CW     = 16
) (
   input  logic               CLK,
   input  logic               RESETn,
   hazard_scoreboard_if.slave hz
);
   localparam int            NREG    = 2**AW;
   localparam logic [AW-1:0] c_pcIdx = AW'(PC_IDX);
   localparam logic          c_fwdEn = (FWD_EN != 0);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t          r_state, w_stateNext;
   logic [NREG-1:0] r_sbPending;
   logic [CW-1:0]   r_stallCnt;

   logic w_srcMatchE, w_srcMatchM, w_ldStall, w_rawStall, w_sbStall, w_mcStall, w_hz;
   logic w_ra1Valid, w_ra2Valid;
   logic w_unused;

   function automatic logic [1:0] fwdSel(input logic [AW-1:0] ra, wa3m, wa3w,
                                         input logic rwm, rww);
      if (!c_fwdEn || ra == c_pcIdx) return 2'b00;
      if (rwm && ra == wa3m)         return 2'b10;
      if (rww && ra == wa3w)         return 2'b01;
      return 2'b00;
   endfunction

   assign hz.ForwardAE = fwdSel(hz.RA1E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
   assign hz.ForwardBE = fwdSel(hz.RA2E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
   assign hz.ForwardM  = c_fwdEn && hz.RA2M != c_pcIdx && hz.RA2M == hz.WA3W &&
                         hz.MemWriteM && hz.MemtoRegW && hz.RegWriteW;

   assign w_ra1Valid  = hz.RA1D != c_pcIdx;
   assign w_ra2Valid  = hz.RA2D != c_pcIdx;
   assign w_srcMatchE = (w_ra1Valid && hz.RA1D == hz.WA3E) || (w_ra2Valid && hz.RA2D == hz.WA3E);
   assign w_srcMatchM = (w_ra1Valid && hz.RA1D == hz.WA3M) || (w_ra2Valid && hz.RA2D == hz.WA3M);

   assign w_ldStall  = w_srcMatchE && hz.RegWriteE && hz.MemtoRegE;
   // Without forwarding, W-stage producers are still covered by the write-first regfile.
   assign w_rawStall = !c_fwdEn && ((w_srcMatchE && hz.RegWriteE) || (w_srcMatchM && hz.RegWriteM));
   assign w_sbStall  = (w_ra1Valid && r_sbPending[hz.RA1D]) ||
                       (w_ra2Valid && r_sbPending[hz.RA2D]) ||
                       (hz.RegWriteD && r_sbPending[hz.WA3D]);
   assign w_mcStall  = hz.MCycleD && (r_state == ST_BUSY) && !hz.MCycleDone;
   assign w_hz       = w_ldStall || w_rawStall || w_sbStall || w_mcStall;

   assign hz.StallF    = w_hz && !hz.PCSrcE;
   assign hz.StallD    = w_hz && !hz.PCSrcE;
   assign hz.FlushD    = hz.PCSrcE;
   assign hz.FlushE    = w_hz || hz.PCSrcE;
   assign hz.MBusy     = (r_state == ST_BUSY);
   assign hz.SbPending = r_sbPending;
   assign hz.StallCnt  = r_stallCnt;

   assign w_unused = hz.MemtoRegM;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_sbPending <= '0;
      end else begin
         if (hz.MCycleDone) r_sbPending[hz.MCycleWA] <= 1'b0;
         // Issued later in the block so a same-index set beats the clear.
         if (hz.MCycleStartE && hz.WA3E != c_pcIdx) r_sbPending[hz.WA3E] <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) r_state <= ST_IDLE;
      else         r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: if (hz.MCycleStartE) w_stateNext = ST_BUSY;
         ST_BUSY: if (hz.MCycleDone && !hz.MCycleStartE) w_stateNext = ST_IDLE;
         default: w_stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn)                           r_stallCnt <= '0;
      else if (hz.StatClr)                   r_stallCnt <= '0;
      else if (hz.StallD && r_stallCnt != '1) r_stallCnt <= r_stallCnt + 1'b1;
   end
endmodule

`default_nettype wire
